poly_tone_sequencer: RTL
========================

# poly_tone_sequencer

Multi-voice, programmable tone sequencer and the parametrised successor to the single-voice `music_processor`. It plays a song from an internal step memory, which is written at run time through a simple write port. Each step holds a duration in milliseconds and one half-period per voice. A sigma-delta mixer combines the voices onto the one-bit speaker pin, and a status byte drives the LED segment. It sits directly under the TinyTapeout top level, fed by `clk`/`rst`, with `sound` on `uio_out[0]` and `led` on `uo_out`.

## Interface

Parameters:
- `VOICES`, default 2: number of square-wave voices, range 1..4.
- `SONG_LEN`, default 16: step-memory depth, power of two, range 2..128.
- `DIV_W`, default 16: half-period width, in clock cycles.
- `MS_W`, default 16: width of `ticks_per_milli`.

Ports (the clock is `clk`; the reset is `rst`, and it is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `ticks_per_milli` in `MS_W`: number of clock cycles per millisecond; a value of 0 is treated as 1.
- `play` in 1: level signal; the sequencer runs while this is high.
- `loop` in 1: when high, the step index wraps to 0 at the end of the song instead of stopping.
- `wr_en` in 1: step-memory write strobe.
- `wr_addr` in clog2(`SONG_LEN`): step-memory write address.
- `wr_data` in 8+`VOICES`*`DIV_W`: step word `{dur_ms[7:0], hp[VOICES-1], …, hp[0]}`.
- `voice` out `VOICES`: raw square wave of each voice.
- `sound` out 1: mixed speaker output, registered.
- `led` out 8: `{playing, step_idx}`, with `step_idx` zero-extended into bits [6:0].
- `done` out 1: one-cycle pulse when the song ends without looping.

## Operation

- **Reset:** state is IDLE; all outputs are 0; `step_idx` is 0; the accumulators and counters are 0. Step-memory contents are not reset.
- **FSM states:** IDLE and PLAY.
  - IDLE → PLAY when `play` is high. Step 0 is loaded.
  - PLAY → IDLE when `play` goes low. No `done` pulse is issued.
  - PLAY → IDLE at the end of the song when `loop` is low. `done` pulses.
- **Step load:** the step word is copied from memory into a step register, then:
  - the ms prescaler, the ms counter and all voice counters are cleared;
  - every `voice` bit is forced to 0.
- **End of song:** reached on the step after `SONG_LEN-1`, or on loading any step whose `dur_ms` is 0 (end marker).
  - A `dur_ms` of 0 at step 0 ends the song immediately.
  - With `loop` high, the end of song reloads step 0. If step 0 is itself an end marker, the sequencer returns to IDLE and `done` pulses.
- **Millisecond prescaler:** counts from 0 to `max(ticks_per_milli,1)-1` and emits `ms_tick` on the wrap.
  - The ms counter increments on each `ms_tick`.
  - When the ms counter equals `dur_ms`, the next step loads.
- **Voice v:**
  - If `hp[v]` is 0, the voice rests and its output is held at 0.
  - Otherwise its counter runs from 0 to `hp[v]-1`; on the terminal count the output toggles and the counter returns to 0.
- **Mixer:**
  - `n` is the number of `voice` bits that are high. The accumulator has width clog2(`VOICES`)+1.
  - Each cycle the mixer computes `s = acc + n`.
  - If `s >= VOICES`, then `sound` is 1 and `acc` becomes `s-VOICES`.
  - Otherwise `sound` is 0 and `acc` becomes `s`.
  - In IDLE, `acc` and `sound` are held at 0.
- **Writes:** accepted in any state. A write changes only the memory; the step currently playing is unaffected, because the step register was latched at load time.
  - A write to the address being loaded in the same cycle: the load sees the old word.
- **Simultaneous events:**
  - `rst` overrides everything.
  - In PLAY, `play` going low takes priority over a step advance in the same cycle.
  - `ticks_per_milli` is sampled continuously. A change mid-step can shorten the current millisecond but never stalls the prescaler (its compare is `>=`).

## Timing

- `play` rising in cycle N: `led[7]` is high and step 0 is active from cycle N+1. The first voice toggle occurs at cycle N+1+`hp`.
- A voice with half-period `hp` has a period of 2·`hp` cycles.
- Step duration is exactly `dur_ms`·`max(ticks_per_milli,1)` cycles from load to the next load.
- `sound` lags `voice` by 1 cycle.
- `done` is high in the cycle in which the state reads IDLE.

## Structure

- Package `tone_seq_pkg` holds:
  - the state enum `{IDLE, PLAY}`;
  - the `DUR_W`=8 constant;
  - a step-word field-offset function.
- Sub-module `tone_voice` (divider plus toggle; ports `clk`, `rst`, `clear`, `hp`, `out`) is instantiated `VOICES` times.
- The step memory is an inferred register array with one write port and one read port.

## Test plan

- **Reset:** assert `rst` mid-PLAY. Next cycle `led`=0, `voice`=0, `sound`=0, `done`=0, and the FSM is in IDLE.
- **Single voice:** `VOICES`=2, `ticks_per_milli`=10, step 0 = `{dur 3, hp1 0, hp0 5}`, step 1 = `dur 0`. Expect `voice[0]` with a period of 10 cycles, `voice[1]` held at 0, and `done` 30 cycles after the step load.
- **Mixer density:** `hp0`=`hp1`=4, in phase. While both voices are high, `sound` is 1 every cycle; while both are low, it is 0.
- **Loop:** a 2-step song with `loop`=1. `step_idx` sequences 0,1,0,1 and `done` never pulses.
- **Abort and write:** drop `play` mid-step; the FSM is in IDLE the next cycle with no `done`. Rewrite step 0 during PLAY; the new data is heard only on the next load of step 0.
- **Edges:** `ticks_per_milli`=0 gives steps of `dur_ms` cycles. A full song of `SONG_LEN` steps with no end marker ends after step `SONG_LEN-1`.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared types and constants for the multi-voice tone sequencer.
// Holds the FSM state enum, the step duration width and the step-word field-offset helper.
// Step word layout: {dur_ms[DUR_W-1:0], hp[VOICES-1], ..., hp[0]}.
package tone_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  localparam int DUR_W = 8;

  // Bit offset of voice v's half-period inside a step word. Calling it with
  // v == VOICES yields the offset of the duration field, which sits above all voices.
  function automatic int hp_lsb(input int v, input int div_w);
    return v * div_w;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: square-wave divider for one voice; output toggles every hp cycles, rests at 0 when hp is 0.
// Latency: output registered; first toggle lands hp cycles after clear is released.
// Backpressure: none; free-running whenever not cleared.
// Ports: clk, rst (sync, active-high), clear (restart phase with output low),
//        hp (half-period in clock cycles), out (square wave).
module tone_voice #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] hp,
  output logic             out
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;
  logic             out_q;

  always_ff @(posedge clk) begin
    if (rst || clear || hp == '0) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else if (cnt_q >= hp - ONE) begin
      cnt_q <= '0;
      out_q <= ~out_q;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/poly_tone_sequencer.sv
// poly_tone_sequencer: plays a song from a run-time writable step memory on VOICES square-wave
//   voices, mixes them to one sigma-delta speaker bit and shows {playing, step_idx} on led.
// Latency: step active the cycle after play rises; sound lags voice by one cycle.
// Backpressure: none; writes accepted every cycle, play is a level enable.
// Ports: clk, rst (sync, active-high), ticks_per_milli (0 acts as 1), play, loop,
//        wr_en/wr_addr/wr_data (step memory write), voice, sound, led, done (song-end pulse).
module poly_tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int VOICES   = 2,
  parameter int SONG_LEN = 16,
  parameter int DIV_W    = 16,
  parameter int MS_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MS_W-1:0]               ticks_per_milli,
  input  logic                          play,
  input  logic                          loop,
  input  logic                          wr_en,
  input  logic [$clog2(SONG_LEN)-1:0]   wr_addr,
  input  logic [DUR_W+VOICES*DIV_W-1:0] wr_data,
  output logic [VOICES-1:0]             voice,
  output logic                          sound,
  output logic [7:0]                    led,
  output logic                          done
);

  localparam int AW      = $clog2(SONG_LEN);
  localparam int WORD_W  = DUR_W + VOICES * DIV_W;
  localparam int DUR_LSB = hp_lsb(VOICES, DIV_W);
  localparam int ACC_W   = $clog2(VOICES) + 1;
  localparam int SW      = ACC_W + 1;

  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]    IDX_LAST = AW'(SONG_LEN - 1);
  localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [SW-1:0]    V_SW     = SW'(VOICES);

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] step_q;
  logic [MS_W-1:0]   presc_q;
  logic [DUR_W-1:0]  ms_q;
  logic              done_q;
  logic [ACC_W-1:0]  acc_q;
  logic              sound_q;

  logic [WORD_W-1:0] mem_q [SONG_LEN];

  logic [WORD_W-1:0] first_word, nxt_word, ld_word;
  logic [AW-1:0]     nxt_idx, ld_idx;
  logic [DUR_W-1:0]  cur_dur, first_dur, nxt_dur;
  logic [MS_W-1:0]   tpm_m1;
  logic              ms_tick, adv, abort, do_load, do_end, stop, voice_clear;
  logic [SW-1:0]     n_hi, mix_sum;
  logic [6:0]        led_idx;

  // Step memory: no reset on contents. The asynchronous reads see the pre-write word,
  // so a load and a write to the same address in one cycle picks up the old data.
  // Step 0 is read alongside the next step so a marker-driven loop reloads without a gap.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= wr_data;
  end

  assign nxt_idx    = idx_q + IDX_ONE;  // wraps at SONG_LEN, which is a power of two
  assign first_word = mem_q[0];
  assign nxt_word   = mem_q[nxt_idx];
  assign first_dur  = first_word[DUR_LSB +: DUR_W];
  assign nxt_dur    = nxt_word[DUR_LSB +: DUR_W];
  assign cur_dur    = step_q[DUR_LSB +: DUR_W];

  // The >= compare lets a mid-step drop in ticks_per_milli wrap at once instead of stalling.
  assign tpm_m1  = (ticks_per_milli == '0) ? '0 : ticks_per_milli - MS_ONE;
  assign ms_tick = (state_q == PLAY) && (presc_q >= tpm_m1);
  // Advance on the dur-th ms tick so a step lasts exactly dur * ticks cycles.
  assign adv     = ms_tick && (ms_q == cur_dur - DUR_ONE);
  assign abort   = (state_q == PLAY) && !play;

  always_comb begin
    do_load = 1'b0;
    do_end  = 1'b0;
    ld_idx  = '0;
    ld_word = first_word;
    if (state_q == IDLE) begin
      if (play) begin
        if (first_dur == '0) do_end = 1'b1;
        else                 do_load = 1'b1;
      end
    end else if (play && adv) begin
      if (idx_q != IDX_LAST && nxt_dur != '0) begin
        do_load = 1'b1;
        ld_idx  = nxt_idx;
        ld_word = nxt_word;
      end else if (loop && first_dur != '0) begin
        do_load = 1'b1;
      end else begin
        do_end = 1'b1;
      end
    end
  end

  assign stop        = abort || do_end;
  assign voice_clear = (state_q == IDLE) || do_load || stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      presc_q <= '0;
      ms_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= do_end;
      if (stop) begin
        state_q <= IDLE;
        idx_q   <= '0;
        presc_q <= '0;
        ms_q    <= '0;
      end else if (do_load) begin
        state_q <= PLAY;
        idx_q   <= ld_idx;
        step_q  <= ld_word;
        presc_q <= '0;
        ms_q    <= '0;
      end else if (state_q == PLAY) begin
        if (ms_tick) begin
          presc_q <= '0;
          ms_q    <= ms_q + DUR_ONE;
        end else begin
          presc_q <= presc_q + MS_ONE;
        end
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    tone_voice #(.DIV_W(DIV_W)) u_voice (
      .clk   (clk),
      .rst   (rst),
      .clear (voice_clear),
      .hp    (step_q[hp_lsb(g, DIV_W) +: DIV_W]),
      .out   (voice[g])
    );
  end

  // First-order sigma-delta: the pin density tracks (voices high) / VOICES.
  always_comb begin
    n_hi = '0;
    for (int i = 0; i < VOICES; i++) n_hi = n_hi + SW'(voice[i]);
    mix_sum = SW'(acc_q) + n_hi;
  end

  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE || stop) begin
      acc_q   <= '0;
      sound_q <= 1'b0;
    end else if (mix_sum >= V_SW) begin
      acc_q   <= ACC_W'(mix_sum - V_SW);
      sound_q <= 1'b1;
    end else begin
      acc_q   <= ACC_W'(mix_sum);
      sound_q <= 1'b0;
    end
  end

  always_comb begin
    led_idx = '0;
    led_idx[AW-1:0] = idx_q;
  end

  assign led   = {state_q == PLAY, led_idx};
  assign sound = sound_q;
  assign done  = done_q;

endmodule
